// File: rtl/vx_issue_unit_arbiter_pkg.sv
// Shared types for the issue-unit arbiter: FSM state encoding and select-width helper.
package vx_issue_unit_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Width of a slice index; a single requester still gets a 1-bit select.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_issue_arb_skid.sv
// Two-entry buffer between the arbiter grant and the shared unit.
// The head entry drives the output directly, so the output is fully registered.
module vx_issue_arb_skid
    import vx_issue_unit_arbiter_pkg::*;
#(
    parameter int BEAT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BEAT_W-1:0] in_beat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BEAT_W-1:0] out_beat
);

    logic [1:0]        count_q, count_d;
    logic [BEAT_W-1:0] head_q, head_d;
    logic [BEAT_W-1:0] tail_q, tail_d;
    logic              ready_q;
    logic              push, pop;

    assign push = in_valid & ready_q;
    assign pop  = (count_q != 2'd0) & out_ready;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = in_beat;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = in_beat;
                end else if (push) begin
                    tail_d  = in_beat;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = in_beat;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
        endcase
    end

    // Ready is registered from the next occupancy, so a pop at full frees the slot one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= (count_d != 2'd2);
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_beat  = head_q;

endmodule

// File: rtl/vx_issue_unit_arbiter.sv
// Round-robin, packet-locked arbiter sharing one execution unit between NUM_REQS issue slices.
// Winning beats pass through a 2-entry registered buffer; stall cycles are counted for perf.
module vx_issue_unit_arbiter
    import vx_issue_unit_arbiter_pkg::*;
#(
    parameter  int NUM_REQS      = 4,
    parameter  int DATAW         = 64,
    parameter  int PERF_CTR_BITS = 44,
    localparam int SEL_W         = sel_width(NUM_REQS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS*DATAW-1:0] req_data,
    input  logic [NUM_REQS-1:0]       req_eop,
    output logic [NUM_REQS-1:0]       req_ready,
    output logic                      out_valid,
    output logic [DATAW-1:0]          out_data,
    output logic                      out_eop,
    output logic [SEL_W-1:0]          out_sel,
    input  logic                      out_ready,
    output logic [PERF_CTR_BITS-1:0]  perf_stalls
);

    typedef struct packed {
        logic [DATAW-1:0] data;
        logic             eop;
        logic [SEL_W-1:0] sel;
    } arb_beat_t;

    localparam logic [SEL_W:0]   NUM_REQS_W = (SEL_W+1)'(NUM_REQS);
    localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(NUM_REQS - 1);

    arb_state_e                state_q;
    logic [SEL_W-1:0]          lock_idx_q;
    logic [SEL_W-1:0]          rr_ptr_q;
    logic [PERF_CTR_BITS-1:0]  perf_q;

    logic [2*NUM_REQS-1:0]     valid_dbl;
    logic [NUM_REQS-1:0]       valid_rot;
    logic                      scan_found;
    logic [SEL_W-1:0]          scan_off;
    logic [SEL_W:0]            scan_sum, scan_wrap;
    logic [SEL_W-1:0]          scan_idx;
    logic                      grant_vld;
    logic [SEL_W-1:0]          grant_idx;
    logic [SEL_W-1:0]          next_ptr;
    logic                      buf_ready;
    logic                      fire;
    arb_beat_t                 push_beat, pop_beat;

    // Rotate so bit 0 is the slice at rr_ptr, then take the lowest set bit.
    assign valid_dbl = {req_valid, req_valid};
    assign valid_rot = valid_dbl[rr_ptr_q +: NUM_REQS];

    always_comb begin
        scan_found = 1'b0;
        scan_off   = '0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                scan_found = 1'b1;
                scan_off   = SEL_W'(k);
            end
        end
    end

    assign scan_sum  = {1'b0, rr_ptr_q} + {1'b0, scan_off};
    assign scan_wrap = scan_sum - NUM_REQS_W;
    assign scan_idx  = (scan_sum >= NUM_REQS_W) ? scan_wrap[SEL_W-1:0] : scan_sum[SEL_W-1:0];

    assign grant_vld = (state_q == ARB_LOCKED) | scan_found;
    assign grant_idx = (state_q == ARB_LOCKED) ? lock_idx_q : scan_idx;
    assign next_ptr  = (grant_idx == LAST_IDX) ? '0 : grant_idx + SEL_W'(1);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            req_ready[i] = grant_vld & buf_ready & (grant_idx == SEL_W'(i));
        end
    end

    assign fire           = |(req_valid & req_ready);
    assign push_beat.data = req_data[int'(grant_idx)*DATAW +: DATAW];
    assign push_beat.eop  = req_eop[grant_idx];
    assign push_beat.sel  = grant_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ARB_IDLE;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
        end else if (fire) begin
            case (state_q)
                ARB_IDLE: begin
                    if (push_beat.eop) begin
                        rr_ptr_q <= next_ptr;
                    end else begin
                        state_q    <= ARB_LOCKED;
                        lock_idx_q <= grant_idx;
                    end
                end
                ARB_LOCKED: begin
                    if (push_beat.eop) begin
                        state_q  <= ARB_IDLE;
                        rr_ptr_q <= next_ptr;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_q <= '0;
        end else if (|req_valid && !fire) begin
            perf_q <= perf_q + PERF_CTR_BITS'(1);
        end
    end

    vx_issue_arb_skid #(
        .BEAT_W ($bits(arb_beat_t))
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (fire),
        .in_ready  (buf_ready),
        .in_beat   (push_beat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_beat  (pop_beat)
    );

    assign out_data    = pop_beat.data;
    assign out_eop     = pop_beat.eop;
    assign out_sel     = pop_beat.sel;
    assign perf_stalls = perf_q;

endmodule

// File: tb/tb_vx_issue_unit_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts grants and buffered beats,
// and a negedge monitor compares every beat the arbiter hands to the shared unit.
module tb_vx_issue_unit_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int PB = 44;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, rst3_n;
    logic [N-1:0]      req_valid, req_eop, req_ready;
    logic [N*DW-1:0]   req_data;
    logic              out_valid, out_eop, out_ready;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_sel;
    logic [PB-1:0]     perf;

    logic [2:0]        v3, e3, rdy3;
    logic [3*DW-1:0]   d3;
    logic              ov3, oe3, or3;
    logic [DW-1:0]     od3;
    logic [1:0]        os3;
    logic [PB-1:0]     perf3;

    vx_issue_unit_arbiter #(.NUM_REQS(N), .DATAW(DW), .PERF_CTR_BITS(PB)) dut (
        .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_eop(req_eop), .req_ready(req_ready), .out_valid(out_valid),
        .out_data(out_data), .out_eop(out_eop), .out_sel(out_sel),
        .out_ready(out_ready), .perf_stalls(perf)
    );

    vx_issue_unit_arbiter #(.NUM_REQS(3), .DATAW(DW), .PERF_CTR_BITS(PB)) dut3 (
        .clk(clk), .reset(rst3_n), .req_valid(v3), .req_data(d3),
        .req_eop(e3), .req_ready(rdy3), .out_valid(ov3),
        .out_data(od3), .out_eop(oe3), .out_sel(os3),
        .out_ready(or3), .perf_stalls(perf3)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          eop;
        logic [1:0]    sel;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    bit              m_locked;
    int              m_owner, m_rr, m_occ;
    bit              m_fresh;
    longint unsigned m_perf;

    bit         p3_on = 1'b0;
    int         p3_k  = 0;
    logic [2:0] p3_v [6] = '{3'b000, 3'b010, 3'b101, 3'b101, 3'b101, 3'b000};
    logic [2:0] p3_r [6] = '{3'b000, 3'b010, 3'b100, 3'b001, 3'b100, 3'b000};
    int         p3_s [6] = '{0, 0, 1, 2, 0, 2};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_rr     = 0;
        m_occ    = 0;
        m_fresh  = 1'b1;
        m_perf   = 0;
        sb.delete();
    endtask

    // One cycle of the reference: who may send, whether it fires, what lands in the buffer.
    task automatic model_step();
        int         g;
        bit         has, rdy, fire, pop;
        logic [N-1:0] exp_rdy;
        beat_t      b;
        chk("out_valid", 64'(out_valid), 64'(m_occ > 0));
        chk("perf_stalls", 64'(perf), m_perf);
        rdy = !m_fresh && (m_occ < 2);
        has = 1'b0;
        g   = 0;
        if (m_locked) begin
            has = 1'b1;
            g   = m_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!has && req_valid[(m_rr + k) % N]) begin
                    has = 1'b1;
                    g   = (m_rr + k) % N;
                end
            end
        end
        exp_rdy = '0;
        if (has && rdy) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        fire = has && rdy && req_valid[g];
        pop  = (m_occ > 0) && out_ready;
        if (req_valid != '0 && !fire) m_perf = (m_perf + 1) & ((64'd1 << PB) - 1);
        if (fire) begin
            b.data = req_data[g*DW +: DW];
            b.eop  = req_eop[g];
            b.sel  = 2'(g);
            sb.push_back(b);
            if (req_eop[g]) begin
                m_locked = 1'b0;
                m_rr     = (g + 1) % N;
            end else begin
                m_locked = 1'b1;
                m_owner  = g;
            end
        end
        m_occ   = m_occ + int'(fire) - int'(pop);
        m_fresh = 1'b0;
    endtask

    task automatic p3_check();
        chk("n3_req_ready", 64'(rdy3), 64'(p3_r[p3_k]));
        if (p3_k >= 2) begin
            chk("n3_out_valid", 64'(ov3), 64'd1);
            chk("n3_out_sel", 64'(os3), 64'(p3_s[p3_k]));
            chk("n3_out_data", od3, 64'h30 + 64'(p3_s[p3_k]));
        end else begin
            chk("n3_out_valid", 64'(ov3), 64'd0);
        end
        p3_k++;
    endtask

    task automatic cycle();
        @(negedge clk);
        #1;
        if (!rst_n) begin
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_data", out_data, 64'd0);
            chk("rst_out_eop", 64'(out_eop), 64'd0);
            chk("rst_out_sel", 64'(out_sel), 64'd0);
            chk("rst_perf", 64'(perf), 64'd0);
        end else begin
            model_step();
        end
        if (p3_on) p3_check();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs(input int ready_pct);
        req_valid = N'($urandom);
        req_eop   = N'($urandom_range(0, 15) & $urandom_range(0, 15));
        for (int i = 0; i < N*DW/32; i++) req_data[i*32 +: 32] = $urandom;
        out_ready = ($urandom_range(0, 99) < ready_pct);
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] e, input logic ordy);
        req_valid = v;
        req_eop   = e;
        out_ready = ordy;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 64'(i) | (64'($urandom) << 8);
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_has_expected_beat", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_eop", 64'(out_eop), 64'(e.eop));
                chk("out_sel", 64'(out_sel), 64'(e.sel));
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        rst3_n = 1'b0;
        drive('0, '0, 1'b0);
        v3  = '0;
        e3  = 3'b111;
        d3  = {64'h32, 64'h31, 64'h30};
        or3 = 1'b1;
        model_reset();

        // Reset held with random inputs; the 3-slice instance runs its wrap sequence meanwhile.
        for (int i = 0; i < 3; i++) begin
            rand_inputs(50);
            cycle();
        end
        rst3_n = 1'b1;
        p3_on  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rand_inputs(50);
            v3 = p3_v[k];
            cycle();
        end
        p3_on = 1'b0;

        // Release; all slices single-beat packets at full throughput.
        rst_n = 1'b1;
        drive(4'b1111, 4'b1111, 1'b1);
        for (int i = 0; i < 9; i++) cycle();
        drive('0, '0, 1'b1);
        repeat (2) cycle();

        // Slice 1 holds the lock for a 3-beat packet while slice 2 waits.
        drive(4'b0110, 4'b0000, 1'b1); cycle();
        drive(4'b0110, 4'b0000, 1'b1); cycle();
        drive(4'b0110, 4'b0010, 1'b1); cycle();
        drive(4'b0100, 4'b0100, 1'b1); cycle();
        drive('0, '0, 1'b1);
        repeat (2) cycle();

        // Backpressure, then drain.
        for (int i = 0; i < 6; i++) begin
            drive(4'b0001, 4'b0001, 1'b0);
            cycle();
        end
        drive('0, '0, 1'b1);
        repeat (4) cycle();

        for (int i = 0; i < 1500; i++) begin
            rand_inputs(70);
            cycle();
        end
        drive(4'b1111, 4'b1111, 1'b1);
        repeat (2) cycle();
        drive('0, '0, 1'b1);
        repeat (4) cycle();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        // Reset while slice 3 is locked with two beats buffered.
        drive(4'b1000, 4'b0000, 1'b0);
        repeat (2) cycle();
        chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        repeat (2) cycle();
        rst_n = 1'b1;
        drive(4'b1111, 4'b1111, 1'b1);
        repeat (3) cycle();
        drive('0, '0, 1'b1);
        repeat (3) cycle();
        chk("sb_final_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
